// File: rtl/kb_fifo.sv
// Scancode FIFO between the PS/2 receiver and the port router, with a toggle-style interrupt handshake.
// Latency: a byte strobed at edge N is on data/status after N; intr toggles at N+1 when no request is outstanding.
// Backpressure: none toward the receiver; bytes arriving while full are dropped and latch the sticky overflow bit.
// Optional: define KB_FIFO_BREAK_FILTER_EN to drop 0xF0 break prefixes and the byte that follows each one.
module kb_fifo #(
  parameter int         DEPTH_LOG2 = 4,
  parameter logic [2:0] VECT       = 3'd0
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       kb_done,
  input  logic [7:0] kb_data,
  input  logic       rd,
  input  logic       flush,
  input  logic       ack,
  output logic [7:0] data,
  output logic [7:0] status,
  output logic       intr,
  output logic [2:0] vect
);

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_PEND = 2'd1,
    IRQ_SERV = 2'd2
  } irq_state_t;

  logic [7:0]            mem [0:(1 << DEPTH_LOG2) - 1];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  overflow;
  logic [4:0]            count_ext;

  logic not_empty;
  logic full;
  logic do_pop;
  logic byte_ok;
  logic do_push;
  logic drop;

  irq_state_t irq_state;
  irq_state_t irq_next;
  logic       intr_toggle;

`ifdef KB_FIFO_BREAK_FILTER_EN
  logic skip;

  // A byte is queued only if it is not a break prefix and not the byte a prefix announced.
  always_comb begin
    byte_ok = kb_done && !skip && (kb_data != 8'hF0);
  end

  // Skip flag: armed by 0xF0, consumed by the next received byte, cleared by flush.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      skip <= 1'b0;
    end else if (flush) begin
      skip <= 1'b0;
    end else if (kb_done) begin
      if (skip) begin
        skip <= 1'b0;
      end else if (kb_data == 8'hF0) begin
        skip <= 1'b1;
      end
    end
  end
`else
  // Every received byte is a candidate for the queue.
  always_comb begin
    byte_ok = kb_done;
  end
`endif

  // Push/pop decisions: a same-cycle pop frees the slot a full-FIFO push needs.
  always_comb begin
    not_empty = (count != '0);
    full      = (count == FULL_CNT);
    do_pop    = rd && not_empty;
    do_push   = byte_ok && (!full || do_pop);
    drop      = byte_ok && full && !do_pop;
  end

  // Pointers, occupancy and sticky overflow; flush overrides any same-cycle traffic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // Byte storage; contents are only visible while count is non-zero, so no reset is needed.
  always_ff @(posedge clock) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= kb_data;
    end
  end

  // Head byte and status word seen by the router.
  always_comb begin
    count_ext = 5'(count);
    data      = not_empty ? mem[rd_ptr] : 8'h00;
    status    = {not_empty, overflow, 1'b0, count_ext};
    vect      = VECT;
  end

  // IRQ state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_state <= IRQ_IDLE;
    end else begin
      irq_state <= irq_next;
    end
  end

  // IRQ next state: raise when data waits, wait for ack, then wait for the CPU to take a byte.
  always_comb begin
    irq_next = irq_state;
    if (flush) begin
      irq_next = IRQ_IDLE;
    end else begin
      case (irq_state)
        IRQ_IDLE: if (not_empty) irq_next = IRQ_PEND;
        IRQ_PEND: if (ack)       irq_next = IRQ_SERV;
        IRQ_SERV: if (do_pop)    irq_next = IRQ_IDLE;
        default:                 irq_next = IRQ_IDLE;
      endcase
    end
  end

  // IRQ output decode: one toggle per new request, never on flush.
  always_comb begin
    intr_toggle = !flush && (irq_state == IRQ_IDLE) && not_empty;
  end

  // Toggle-style request line toward the core.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      intr <= 1'b0;
    end else if (intr_toggle) begin
      intr <= ~intr;
    end
  end

endmodule

// File: tb/tb_kb_fifo.sv
// Self-checking bench for kb_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model of the buffer and request line.
module tb_kb_fifo;

  localparam int         DL2   = 4;
  localparam int         DEPTH = 16;
  localparam logic [2:0] VEC   = 3'd5;

  logic       clock;
  logic       reset_n;
  logic       kb_done;
  logic [7:0] kb_data;
  logic       rd;
  logic       flush;
  logic       ack;
  logic [7:0] data;
  logic [7:0] status;
  logic       intr;
  logic [2:0] vect;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] mq[$];
  bit         m_ovf;
  bit         m_skip;
  bit         m_intr;
  int         m_irq;   // 0 no request, 1 raised awaiting ack, 2 acknowledged awaiting a read

  kb_fifo #(.DEPTH_LOG2(DL2), .VECT(VEC)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .kb_done (kb_done),
    .kb_data (kb_data),
    .rd      (rd),
    .flush   (flush),
    .ack     (ack),
    .data    (data),
    .status  (status),
    .intr    (intr),
    .vect    (vect)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply this cycle's inputs to the model (pre-edge state decides everything).
  task automatic model_edge();
    int n;
    bit pop_ok;
    bit take;
    n      = mq.size();
    pop_ok = rd && (n > 0);
    if (flush) begin
      mq.delete();
      m_ovf  = 0;
      m_skip = 0;
      m_irq  = 0;
    end else begin
      case (m_irq)
        0: if (n != 0) begin m_intr = ~m_intr; m_irq = 1; end
        1: if (ack) m_irq = 2;
        default: if (pop_ok) m_irq = 0;
      endcase
      take = kb_done;
`ifdef KB_FIFO_BREAK_FILTER_EN
      if (kb_done) begin
        if (m_skip) begin
          take = 0; m_skip = 0;
        end else if (kb_data == 8'hF0) begin
          take = 0; m_skip = 1;
        end
      end
`endif
      if (pop_ok) void'(mq.pop_front());
      if (take) begin
        if (n < DEPTH || pop_ok) mq.push_back(kb_data);
        else m_ovf = 1;
      end
    end
  endtask

  function automatic logic [7:0] model_data();
    return (mq.size() > 0) ? mq[0] : 8'h00;
  endfunction

  function automatic logic [7:0] model_status();
    logic [4:0] c;
    c = 5'(mq.size());
    return {mq.size() > 0, m_ovf, 1'b0, c};
  endfunction

  // One clock: drive strobes, update model, clock, leave outputs settled 1ns after the edge.
  task automatic cyc(input logic d, input logic [7:0] b, input logic r, input logic f, input logic a);
    kb_done = d; kb_data = b; rd = r; flush = f; ack = a;
    model_edge();
    @(posedge clock);
    #1;
    kb_done = 0; rd = 0; flush = 0; ack = 0;
  endtask

  task automatic do_reset();
    kb_done = 0; kb_data = 8'h00; rd = 0; flush = 0; ack = 0;
    reset_n = 0;
    mq.delete(); m_ovf = 0; m_skip = 0; m_intr = 0; m_irq = 0;
    #7;
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_reset();
    kb_done = 0; kb_data = 8'h00; rd = 0; flush = 0; ack = 0;
    reset_n = 0;
    #3;
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", data); end
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL reset_status: got %h want 00", status); end
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL reset_intr: got %b want 0", intr); end
    checks++; if (vect !== VEC) begin failures++; $display("FAIL vect: got %0d want %0d", vect, VEC); end
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    cyc(1, 8'h1C, 0, 0, 0);
    checks++; if (data !== 8'h1C) begin failures++; $display("FAIL basic_data: got %h want 1c", data); end
    checks++; if (status !== 8'h81) begin failures++; $display("FAIL basic_status: got %h want 81", status); end
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL basic_intr_early: got %b want 0", intr); end
    cyc(0, 8'h00, 0, 0, 0);
    checks++; if (intr !== 1'b1) begin failures++; $display("FAIL basic_intr_raise: got %b want 1", intr); end
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 1, 0, 0);
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL basic_status_empty: got %h want 00", status); end
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL basic_data_empty: got %h want 00", data); end
    repeat (3) cyc(0, 8'h00, 0, 0, 0);
    checks++; if (intr !== 1'b1) begin failures++; $display("FAIL basic_no_retoggle: got %b want 1", intr); end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    do_reset();
    for (int i = 1; i <= 17; i++) cyc(1, 8'(i), 0, 0, 0);
    checks++; if (status !== 8'hD0) begin failures++; $display("FAIL ovf_status: got %h want d0", status); end
    for (int i = 1; i <= 16; i++) begin
      b = 8'(i);
      checks++; if (data !== b) begin failures++; $display("FAIL ovf_pop%0d: got %h want %h", i, data, b); end
      cyc(0, 8'h00, 1, 0, 0);
    end
    checks++; if (status !== 8'h40) begin failures++; $display("FAIL ovf_sticky: got %h want 40", status); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 16; i++) cyc(1, 8'hA0 + 8'(i), 0, 0, 0);
    checks++; if (status !== 8'h90) begin failures++; $display("FAIL full_status: got %h want 90", status); end
    cyc(1, 8'h55, 1, 0, 0);
    checks++; if (status !== 8'h90) begin failures++; $display("FAIL full_pushpop_status: got %h want 90", status); end
    for (int i = 1; i <= 16; i++) begin
      b = (i == 16) ? 8'h55 : 8'hA0 + 8'(i);
      checks++; if (data !== b) begin failures++; $display("FAIL full_read%0d: got %h want %h", i, data, b); end
      cyc(0, 8'h00, 1, 0, 0);
    end
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL full_drained: got %h want 00", status); end
  endtask

  task automatic test_irq_handshake();
    do_reset();
    cyc(1, 8'h11, 0, 0, 0);
    cyc(1, 8'h22, 0, 0, 0);
    checks++; if (intr !== 1'b1) begin failures++; $display("FAIL irq_first: got %b want 1", intr); end
    cyc(0, 8'h00, 0, 0, 0);
    checks++; if (intr !== 1'b1) begin failures++; $display("FAIL irq_once: got %b want 1", intr); end
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 1, 0, 0);
    checks++; if (intr !== 1'b1) begin failures++; $display("FAIL irq_at_pop: got %b want 1", intr); end
    cyc(0, 8'h00, 0, 0, 0);
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL irq_second: got %b want 0", intr); end
    cyc(0, 8'h00, 0, 0, 1);
    cyc(0, 8'h00, 1, 0, 0);
    repeat (3) cyc(0, 8'h00, 0, 0, 0);
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL irq_no_third: got %b want 0", intr); end
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL irq_empty: got %h want 00", status); end
  endtask

  task automatic test_flush();
    do_reset();
    cyc(1, 8'h01, 0, 0, 0);
    cyc(1, 8'h02, 0, 0, 0);
    cyc(1, 8'h03, 0, 0, 0);
    checks++; if (intr !== 1'b1) begin failures++; $display("FAIL flush_pre_intr: got %b want 1", intr); end
    cyc(1, 8'h77, 0, 1, 0);
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL flush_status: got %h want 00", status); end
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL flush_data: got %h want 00", data); end
    repeat (2) cyc(0, 8'h00, 0, 0, 0);
    checks++; if (intr !== 1'b1) begin failures++; $display("FAIL flush_intr: got %b want 1", intr); end
    cyc(1, 8'h44, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL flush_idle_reraise: got %b want 0", intr); end
    checks++; if (data !== 8'h44) begin failures++; $display("FAIL flush_next_byte: got %h want 44", data); end
  endtask

  task automatic test_filter();
    logic [7:0] seq [5];
    seq[0] = 8'h1C; seq[1] = 8'hF0; seq[2] = 8'h1C; seq[3] = 8'hE0; seq[4] = 8'h75;
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1, seq[i], 0, 0, 0);
`ifdef KB_FIFO_BREAK_FILTER_EN
    checks++; if (status !== 8'h83) begin failures++; $display("FAIL filt_status: got %h want 83", status); end
    checks++; if (data !== 8'h1C) begin failures++; $display("FAIL filt_pop0: got %h want 1c", data); end
    cyc(0, 8'h00, 1, 0, 0);
    checks++; if (data !== 8'hE0) begin failures++; $display("FAIL filt_pop1: got %h want e0", data); end
    cyc(0, 8'h00, 1, 0, 0);
    checks++; if (data !== 8'h75) begin failures++; $display("FAIL filt_pop2: got %h want 75", data); end
`else
    checks++; if (status !== 8'h85) begin failures++; $display("FAIL nofilt_status: got %h want 85", status); end
    cyc(0, 8'h00, 1, 0, 0);
    checks++; if (data !== 8'hF0) begin failures++; $display("FAIL nofilt_f0: got %h want f0", data); end
`endif
  endtask

  task automatic test_random();
    logic d, r, f, a;
    logic [7:0] b;
    logic [7:0] ed, es;
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      d = ($urandom_range(99) < 55);
      r = ($urandom_range(99) < (((i / 150) % 2 == 0) ? 15 : 60));
      a = ($urandom_range(99) < 30);
      f = ($urandom_range(199) < 3);
      b = ($urandom_range(9) == 0) ? 8'hF0 : 8'($urandom);
      cyc(d, b, r, f, a);
      ed = model_data();
      es = model_status();
      checks++; if (data !== ed) begin failures++; $display("FAIL rand_data@%0d: got %h want %h", i, data, ed); end
      checks++; if (status !== es) begin failures++; $display("FAIL rand_status@%0d: got %h want %h", i, status, es); end
      checks++; if (intr !== m_intr) begin failures++; $display("FAIL rand_intr@%0d: got %b want %b", i, intr, m_intr); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cyc(1, 8'h31, 0, 0, 0);
    cyc(1, 8'h32, 0, 0, 0);
    cyc(0, 8'h00, 0, 0, 0);
    checks++; if (intr !== 1'b1) begin failures++; $display("FAIL areset_pre: got %b want 1", intr); end
    @(negedge clock);
    #2;
    reset_n = 0;
    #1;
    checks++; if (intr !== 1'b0) begin failures++; $display("FAIL areset_intr: got %b want 0", intr); end
    checks++; if (status !== 8'h00) begin failures++; $display("FAIL areset_status: got %h want 00", status); end
    checks++; if (data !== 8'h00) begin failures++; $display("FAIL areset_data: got %h want 00", data); end
    do_reset();
  endtask

  initial begin
    reset_n = 1'b0;
    kb_done = 0; kb_data = 8'h00; rd = 0; flush = 0; ack = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_irq_handshake();
    test_flush();
    test_filter();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kb_fifo.md
# kb_fifo

Scancode buffer between the PS/2 receiver (`kb`) and the AVR port router. It queues bytes from the receiver's one-cycle `done` strobe and presents the head byte and a status byte to the router for ports 0x20/0x23. It drives the core's toggle-style `intr`/`vect` lines with a handshake, so bytes arriving while the core is busy are not lost. Runs on `clock_25`, replacing the single `kb` register in the router.

## Interface

Parameters:
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 bytes. Legal range 2..4.
- `VECT`, 3'd0: interrupt vector number driven on `vect`.

Ports:
- `clock`  in  1  system clock (25 MHz domain).
- `reset_n`  in  1  asynchronous, active-low reset.
- `kb_done`  in  1  one-cycle strobe from the PS/2 receiver: `kb_data` is valid.
- `kb_data`  in  8  received scancode.
- `rd`  in  1  pop strobe. The router asserts it for one cycle when the CPU reads port 0x20 (`read` and address match).
- `flush`  in  1  one-cycle strobe. The router asserts it on a CPU write to port 0x23.
- `ack`  in  1  interrupt-acknowledge pulse from the core.
- `data`  out  8  head byte. 0x00 when empty. Combinational from the FIFO storage.
- `status`  out  8  bit7 = not empty, bit6 = sticky overflow, bits5 = 0, bits4:0 = count.
- `intr`  out  1  interrupt request. Each toggle is one request.
- `vect`  out  3  constant `VECT`.

## Operation

- Storage: register array with read pointer, write pointer and count. Pointers wrap modulo depth. Count is DEPTH_LOG2+1 bits, zero-extended into status[4:0].
- Push on `kb_done` when count < depth. When full, the byte is dropped and `overflow` is set.
- Pop on `rd` when count > 0. `rd` when empty has no effect.
- Push and pop in the same cycle:
  - non-empty: both happen and count is unchanged;
  - full: the pop frees a slot, so the push is accepted and overflow is not set;
  - empty: the push is accepted and the pop is ignored.
- `overflow` is cleared only by `flush` or by reset.
- `flush` resets pointers, count and overflow, and forces the IRQ state to IDLE. `flush` wins over a same-cycle push or pop. `intr` does not toggle on flush.
- IRQ state machine:
  - IDLE: if count != 0, toggle `intr` and go to PEND.
  - PEND: on `ack`, go to SERV. Pops in PEND are allowed but do not change state.
  - SERV: on a `rd` that pops a byte, go to IDLE. If bytes remain, IDLE re-raises the request on the next cycle.
  - `ack` in IDLE or SERV is ignored.
- Reset values: pointers, count and overflow = 0; state = IDLE; `intr` = 0; `data` = 0x00; `status` = 0x00; `vect` = `VECT`.

## Timing

- `kb_done` sampled at edge N: the byte is visible on `data`/`status` after edge N.
- If the state is IDLE, `intr` toggles at edge N+1.
- A pop at edge M advances `data` to the next byte after edge M.
- `ack` at edge A enters SERV at A. A pop at edge P > A returns to IDLE at P.
- Minimum spacing between consecutive `intr` toggles is 3 cycles (IDLE→PEND, ack, pop).
- Reset is asynchronous. Asserting it mid-operation clears everything immediately, including a pending request. `intr` returns to 0, which the core may see as one toggle; the core is held in reset by the same signal.

## Configuration

- `KB_FIFO_BREAK_FILTER_EN` defined:
  - incoming 0xF0 is not pushed; it sets a skip flag;
  - the next received byte is discarded and clears the flag;
  - only make codes (including 0xE0 prefixes) enter the FIFO;
  - the skip flag resets to 0 and is cleared by `flush`;
  - a discarded byte never sets overflow.
- Not defined: every received byte is pushed unchanged.

## Test plan

- Reset, then `kb_done` with 0x1C at edge 0 → after edge 0, `data` = 0x1C and `status` = 0x81; `intr` toggles 0→1 at edge 1; `ack` then `rd` → `status` = 0x00, state IDLE, no further toggle.
- Push 17 bytes 0x01..0x11 with DEPTH_LOG2 = 4 and no pops → `status` = 0xD0 (not empty, overflow, count 16); popping all 16 returns 0x01..0x10 in order with pointer wrap, and 0x11 is lost.
- With FIFO full, `kb_done` 0x55 in the same cycle as `rd` → count stays 16, overflow stays 0, and 0x55 becomes the last byte read.
- Two bytes queued: `intr` toggles once; `ack` then `rd` → `intr` toggles again exactly 1 cycle after the pop; a second `ack` and `rd` → empty, no third toggle.
- `flush` in PEND with 3 bytes queued and a same-cycle `kb_done` → `status` = 0x00, state IDLE, `intr` unchanged, and the pushed byte is discarded.
- With `KB_FIFO_BREAK_FILTER_EN` defined, feed 0x1C, 0xF0, 0x1C, 0xE0, 0x75 → pops return 0x1C, 0xE0, 0x75; `status` shows count 3 before any pops.
